// File: rtl/amplitude_modulator_mc_if.sv
// ---------------------------------------------------------------------------
// amplitude_modulator_mc_if
//   Sample/gain bus of the multi-channel amplitude modulator.
//   master : channel scheduler / gain control side (drives samples and gains)
//   slave  : modulator side (drives the scaled output stream)
//   Signals:
//     din, din_valid, din_ch           signed sample in, strobe, channel tag
//     amp_target, amp_wr, amp_ch       gain write: value, strobe, channel
//     dout, dout_valid, dout_ch        scaled sample out, strobe, channel tag
// ---------------------------------------------------------------------------
interface amplitude_modulator_mc_if #(
    parameter int DATA_BITS      = 12,
    parameter int AMPLITUDE_BITS = 8,
    parameter int CH_BITS        = 2
);
    logic signed [DATA_BITS-1:0]      din;
    logic                             din_valid;
    logic        [CH_BITS-1:0]        din_ch;
    logic        [AMPLITUDE_BITS-1:0] amp_target;
    logic                             amp_wr;
    logic        [CH_BITS-1:0]        amp_ch;
    logic signed [DATA_BITS-1:0]      dout;
    logic                             dout_valid;
    logic        [CH_BITS-1:0]        dout_ch;

    modport master (
        output din, din_valid, din_ch, amp_target, amp_wr, amp_ch,
        input  dout, dout_valid, dout_ch
    );

    modport slave (
        input  din, din_valid, din_ch, amp_target, amp_wr, amp_ch,
        output dout, dout_valid, dout_ch
    );
endinterface

// File: rtl/amplitude_modulator_mc.sv
// ---------------------------------------------------------------------------
// amplitude_modulator_mc
//   Time-multiplexed multi-channel amplitude modulator. Each accepted sample
//   is scaled by its channel's current gain (amplitude / 2^AMPLITUDE_BITS).
//   The current gain ramps toward the written target by at most SLEW_STEP
//   per processed sample of that channel, avoiding zipper noise.
//   Pipeline: accept/gain lookup -> multiply -> output (2-edge latency).
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      slave side of amplitude_modulator_mc_if (samples, gain
//              writes, scaled output stream)
// ---------------------------------------------------------------------------
module amplitude_modulator_mc #(
    parameter int DATA_BITS      = 12,
    parameter int AMPLITUDE_BITS = 8,
    parameter int CHANNELS       = 4,
    parameter int CH_BITS        = 2,
    parameter int SLEW_STEP      = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    amplitude_modulator_mc_if.slave  bus
);

    localparam int PROD_BITS = DATA_BITS + AMPLITUDE_BITS + 1;
    localparam int CHB1      = CH_BITS + 1;

    localparam logic [CH_BITS:0]          CH_LIMIT = CHB1'(CHANNELS);
    localparam logic [AMPLITUDE_BITS-1:0] STEP     = AMPLITUDE_BITS'(SLEW_STEP);

    // Per-channel gain state
    logic [AMPLITUDE_BITS-1:0] r_target [CHANNELS];
    logic [AMPLITUDE_BITS-1:0] r_cur    [CHANNELS];

    // Stage 1: accepted sample with the gain it will use
    logic                        r_s1_valid;
    logic signed [DATA_BITS-1:0] r_s1_din;
    logic [CH_BITS-1:0]          r_s1_ch;
    logic [AMPLITUDE_BITS-1:0]   r_s1_gain;

    // Stage 2: full-precision product
    logic                        r_s2_valid;
    logic [CH_BITS-1:0]          r_s2_ch;
    logic signed [DATA_BITS-1:0] r_s2_dout;

    // Output registers
    logic signed [DATA_BITS-1:0] r_dout;
    logic                        r_dout_valid;
    logic [CH_BITS-1:0]          r_dout_ch;

    logic                          w_accept;
    logic [AMPLITUDE_BITS-1:0]     w_gain;
    logic [AMPLITUDE_BITS-1:0]     w_tgt;
    logic [AMPLITUDE_BITS-1:0]     w_diff;
    logic [AMPLITUDE_BITS-1:0]     w_cur_next;
    logic signed [PROD_BITS-1:0]   w_product;
    logic                          w_unused_prod_bits;

    // Out-of-range channels are dropped with no state change.
    assign w_accept = bus.din_valid && ({1'b0, bus.din_ch} < CH_LIMIT);

    // Gain/target lookup for the incoming channel; the loop keeps indices
    // within the array even when CHANNELS < 2^CH_BITS.
    always_comb begin
        w_gain = '0;
        w_tgt  = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (bus.din_ch == CH_BITS'(c)) begin
                w_gain = r_cur[c];
                w_tgt  = r_target[c];
            end
        end
    end

    // Single shared slew unit: moves the selected channel's gain toward its
    // (pre-edge) target, clamping to the target so it never overshoots.
    always_comb begin
        w_diff     = '0;
        w_cur_next = w_gain;
        if (w_tgt >= w_gain) begin
            w_diff = w_tgt - w_gain;
            if (w_diff <= STEP) begin
                w_cur_next = w_tgt;
            end else begin
                w_cur_next = w_gain + STEP;
            end
        end else begin
            w_diff = w_gain - w_tgt;
            if (w_diff <= STEP) begin
                w_cur_next = w_tgt;
            end else begin
                w_cur_next = w_gain - STEP;
            end
        end
    end

    // Gain state. A same-edge gain write on the sampled channel only changes
    // the target (the slew above already used the old one); with no slew the
    // write also lands in cur, overriding the slew result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                r_target[c] <= '0;
                r_cur[c]    <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (w_accept && (bus.din_ch == CH_BITS'(c))) begin
                    r_cur[c] <= w_cur_next;
                end
                if (bus.amp_wr && (bus.amp_ch == CH_BITS'(c))) begin
                    r_target[c] <= bus.amp_target;
                    if (SLEW_STEP == 0) begin
                        r_cur[c] <= bus.amp_target;
                    end
                end
            end
        end
    end

    // Stage 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_din   <= '0;
            r_s1_ch    <= '0;
            r_s1_gain  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_din  <= bus.din;
                r_s1_ch   <= bus.din_ch;
                r_s1_gain <= w_gain;
            end
        end
    end

    // Gain is zero-extended so it multiplies as a non-negative value; the
    // result cannot overflow PROD_BITS.
    assign w_product = r_s1_din * $signed({1'b0, r_s1_gain});

    // Only the arithmetic-shifted window is kept; sign bit above it is a
    // copy and the low bits are discarded (floor toward -inf).
    assign w_unused_prod_bits = ^{w_product[PROD_BITS-1], w_product[AMPLITUDE_BITS-1:0]};

    // Stage 2
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_ch    <= '0;
            r_s2_dout  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_ch   <= r_s1_ch;
                r_s2_dout <= w_product[DATA_BITS+AMPLITUDE_BITS-1 -: DATA_BITS];
            end
        end
    end

    // Output stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_ch    <= '0;
        end else begin
            r_dout_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_dout    <= r_s2_dout;
                r_dout_ch <= r_s2_ch;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.dout_ch    = r_dout_ch;

endmodule

// File: tb/tb_amplitude_modulator_mc.sv
// ---------------------------------------------------------------------------
// tb_amplitude_modulator_mc
//   Directed bench for amplitude_modulator_mc. Two instances: one with no
//   slew (3-bit channel tag so out-of-range channels can be driven) and one
//   with SLEW_STEP = 4. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_amplitude_modulator_mc;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    amplitude_modulator_mc_if #(.DATA_BITS(12), .AMPLITUDE_BITS(8), .CH_BITS(3)) bus0 ();
    amplitude_modulator_mc_if #(.DATA_BITS(12), .AMPLITUDE_BITS(8), .CH_BITS(2)) bus4 ();

    amplitude_modulator_mc #(
        .DATA_BITS(12), .AMPLITUDE_BITS(8), .CHANNELS(4), .CH_BITS(3), .SLEW_STEP(0)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );

    amplitude_modulator_mc #(
        .DATA_BITS(12), .AMPLITUDE_BITS(8), .CHANNELS(4), .CH_BITS(2), .SLEW_STEP(4)
    ) u_dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Stream vectors
    int s_din [64];
    int s_ch  [64];
    int s_tgt [64];
    bit s_vld [64];
    bit s_wr  [64];
    bit e_vld [64];
    int e_dout[64];
    int e_ch  [64];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input bit v, input int d, input int ch,
                         input bit wr, input int tgt, input int ach);
        if (sel == 0) begin
            bus0.din        = 12'(d);
            bus0.din_valid  = v;
            bus0.din_ch     = 3'(ch);
            bus0.amp_wr     = wr;
            bus0.amp_target = 8'(tgt);
            bus0.amp_ch     = 3'(ach);
        end else begin
            bus4.din        = 12'(d);
            bus4.din_valid  = v;
            bus4.din_ch     = 2'(ch);
            bus4.amp_wr     = wr;
            bus4.amp_target = 8'(tgt);
            bus4.amp_ch     = 2'(ach);
        end
    endtask

    task automatic idle();
        drive(0, 1'b0, 0, 0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    function automatic int obs_dout(input int sel);
        return (sel == 0) ? int'(bus0.dout) : int'(bus4.dout);
    endfunction

    function automatic int obs_valid(input int sel);
        return (sel == 0) ? int'(bus0.dout_valid) : int'(bus4.dout_valid);
    endfunction

    function automatic int obs_ch(input int sel);
        return (sel == 0) ? int'(bus0.dout_ch) : int'(bus4.dout_ch);
    endfunction

    task automatic write_amp(input int sel, input int ch, input int tgt);
        drive(sel, 1'b0, 0, 0, 1'b1, tgt, ch);
        tick();
        idle();
    endtask

    // One isolated sample: no output after one edge, pulse after two, gone after three.
    task automatic single(input int sel, input int d, input int ch, input int exp, input string tag);
        drive(sel, 1'b1, d, ch, 1'b0, 0, 0);
        tick();
        idle();
        tick();
        check_val({tag, "_lat"}, obs_valid(sel), 0);
        tick();
        check_val({tag, "_valid"}, obs_valid(sel), 1);
        check_val({tag, "_dout"}, obs_dout(sel), exp);
        check_val({tag, "_ch"}, obs_ch(sel), ch);
        tick();
        check_val({tag, "_pulse"}, obs_valid(sel), 0);
    endtask

    task automatic clear_vec();
        for (int i = 0; i < 64; i++) begin
            s_din[i] = 0; s_ch[i] = 0; s_tgt[i] = 0; s_vld[i] = 0; s_wr[i] = 0;
            e_vld[i] = 0; e_dout[i] = 0; e_ch[i] = 0;
        end
    endtask

    // Back-to-back stream; output for vector k is checked two edges later.
    task automatic run_stream(input int sel, input int n, input string tag);
        for (int k = 0; k < n + 2; k++) begin
            if (k < n) drive(sel, s_vld[k], s_din[k], s_ch[k], s_wr[k], s_tgt[k], s_ch[k]);
            else       idle();
            tick();
            if (k >= 2) begin
                check_val($sformatf("%s_valid%0d", tag, k - 2), obs_valid(sel), int'(e_vld[k-2]));
                if (e_vld[k-2]) begin
                    check_val($sformatf("%s_dout%0d", tag, k - 2), obs_dout(sel), e_dout[k-2]);
                    check_val($sformatf("%s_ch%0d", tag, k - 2), obs_ch(sel), e_ch[k-2]);
                end
            end
        end
        idle();
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        tick();
        tick();
        check_val("rst_dout", obs_dout(0), 0);
        check_val("rst_valid", obs_valid(0), 0);
        check_val("rst_ch", obs_ch(0), 0);
        check_val("rst_valid4", obs_valid(1), 0);
        reset_n = 1'b1;
        tick();

        // No-slew scaling
        write_amp(0, 0, 128);
        single(0, 2047, 0, 1023, "half");
        write_amp(0, 1, 255);
        single(0, -2048, 1, -2040, "maxgain");
        write_amp(0, 1, 1);
        single(0, -1, 1, -1, "floor");

        // Interleaved channels plus an out-of-range channel
        write_amp(0, 1, 64);
        write_amp(0, 2, 200);
        write_amp(0, 3, 32);
        clear_vec();
        s_vld[0] = 1; s_din[0] = 1000;  s_ch[0] = 0; e_vld[0] = 1; e_dout[0] = 500;  e_ch[0] = 0;
        s_vld[1] = 1; s_din[1] = -1000; s_ch[1] = 1; e_vld[1] = 1; e_dout[1] = -250; e_ch[1] = 1;
        s_vld[2] = 1; s_din[2] = 512;   s_ch[2] = 2; e_vld[2] = 1; e_dout[2] = 400;  e_ch[2] = 2;
        s_vld[3] = 1; s_din[3] = -7;    s_ch[3] = 3; e_vld[3] = 1; e_dout[3] = -1;   e_ch[3] = 3;
        s_vld[4] = 1; s_din[4] = 100;   s_ch[4] = 5; e_vld[4] = 0;
        run_stream(0, 5, "ilv");

        // Gain write to a nonexistent channel must not alias onto ch 0
        write_amp(0, 4, 255);
        single(0, 1000, 0, 500, "badwr");

        // Slew ramp 0 -> 100 on ch 2
        write_amp(1, 2, 100);
        clear_vec();
        for (int j = 0; j < 30; j++) begin
            s_vld[j] = 1; s_din[j] = 256; s_ch[j] = 2;
            e_vld[j] = 1; e_ch[j] = 2;
            e_dout[j] = (j <= 24) ? 4 * j : 100;
        end
        run_stream(1, 30, "ramp");
        tick();
        check_val("ramp_end", obs_valid(1), 0);

        // Small step: no overshoot
        write_amp(1, 2, 102);
        clear_vec();
        for (int j = 0; j < 2; j++) begin
            s_vld[j] = 1; s_din[j] = 256; s_ch[j] = 2; e_vld[j] = 1; e_ch[j] = 2;
        end
        e_dout[0] = 100;
        e_dout[1] = 102;
        run_stream(1, 2, "near");

        // Ramp ch 0 up to 50, then same-edge target write of 0 with a sample
        write_amp(1, 0, 50);
        clear_vec();
        for (int j = 0; j < 13; j++) begin
            s_vld[j] = 1; s_din[j] = 0; s_ch[j] = 0; e_vld[j] = 1; e_dout[j] = 0; e_ch[j] = 0;
        end
        run_stream(1, 13, "up50");
        clear_vec();
        for (int j = 0; j < 4; j++) begin
            s_vld[j] = 1; s_din[j] = 256; s_ch[j] = 0; e_vld[j] = 1; e_ch[j] = 0;
        end
        s_wr[0] = 1; s_tgt[0] = 0;
        e_dout[0] = 50; e_dout[1] = 50; e_dout[2] = 46; e_dout[3] = 42;
        run_stream(1, 4, "same");

        // Reset with samples in flight (ch 2 sits at gain 102)
        for (int j = 0; j < 3; j++) begin
            drive(1, 1'b1, 256, 2, 1'b0, 0, 0);
            tick();
        end
        idle();
        check_val("pre_rst_valid", obs_valid(1), 1);
        check_val("pre_rst_dout", obs_dout(1), 102);
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_valid", obs_valid(1), 0);
        check_val("mid_rst_dout", obs_dout(1), 0);
        tick();
        reset_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            check_val($sformatf("post_rst_quiet%0d", j), obs_valid(1), 0);
        end
        single(1, 256, 2, 0, "post_rst_a");
        single(1, 256, 2, 0, "post_rst_b");
        single(0, 2047, 0, 0, "post_rst_c");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/amplitude_modulator_mc.md
Name: amplitude_modulator_mc

Overview:
Multi-channel, time-multiplexed successor to the single-voice amplitude modulator. Scales signed voice samples by a per-channel unsigned amplitude and streams the results out with a valid strobe and channel tag. Each channel ramps toward its written target gain by a bounded step per processed sample, which removes zipper noise on gain changes. The block sits between the voice mixer's channel scheduler and the ADSR/volume controls.

Parameters:
DATA_BITS, 12, width of signed sample in and out
AMPLITUDE_BITS, 8, width of unsigned gain; gain = amplitude / 2^AMPLITUDE_BITS
CHANNELS, 4, number of independent channels (>=1)
CH_BITS, 2, channel index width; must satisfy 2^CH_BITS >= CHANNELS
SLEW_STEP, 4, max change of current gain per processed sample on that channel; 0 = no slew, target applies immediately

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
din  in  DATA_BITS  signed input sample
din_valid  in  1  din/din_ch valid this cycle
din_ch  in  CH_BITS  channel of din
amp_target  in  AMPLITUDE_BITS  new target gain
amp_wr  in  1  write amp_target to channel amp_ch
amp_ch  in  CH_BITS  channel for gain write
dout  out  DATA_BITS  signed scaled sample
dout_valid  out  1  dout/dout_ch valid, one-cycle pulse per accepted sample
dout_ch  out  CH_BITS  channel of dout

Behaviour:
- Reset (async assert, sync release): target[] = 0, cur[] = 0, pipeline valid bits = 0, dout = 0, dout_valid = 0, dout_ch = 0. Reset mid-stream discards in-flight samples; no output pulse follows.
- No backpressure: one sample per cycle max, always accepted if din_ch < CHANNELS.
- din_valid with din_ch >= CHANNELS: sample dropped, no output, no state change.
- Stage 1 (cycle of acceptance edge): register din, din_ch and gain g = cur[din_ch] as held before this edge; in the same edge update cur[din_ch]:
  - if |target - cur| <= SLEW_STEP: cur <= target
  - else cur <= cur +/- SLEW_STEP toward target; never overshoots, never wraps
  - SLEW_STEP = 0: cur follows target with no ramp; see write rule
- Stage 2: product = din * {1'b0, g}, signed, DATA_BITS+AMPLITUDE_BITS+1 bits, no overflow possible. dout = product bits [DATA_BITS+AMPLITUDE_BITS-1 -: DATA_BITS] (arithmetic right shift by AMPLITUDE_BITS, truncation toward -inf). dout_valid and dout_ch are registered alongside.
- Latency: din_valid sampled at edge N -> dout_valid high after edge N+2, for one cycle. Back-to-back input gives back-to-back output in order.
- Gain write: amp_wr at edge -> target[amp_ch] <= amp_target. amp_ch >= CHANNELS is ignored. With SLEW_STEP = 0, cur[amp_ch] <= amp_target at the same edge.
- Simultaneous amp_wr and din_valid on the same channel: the sample uses the old cur; the slew update in that edge moves toward the OLD target; the new target governs from the next sample on. With SLEW_STEP = 0, the new value is written to cur, and the sample still uses the old cur.
- Slew advances only on samples for that channel; idle channels hold cur.
- Max gain (2^AMPLITUDE_BITS - 1) is slightly below unity, by design.

Test Plan:
- Reset, target[0] = 128 with SLEW_STEP = 0, din = 2047 on ch 0 -> two cycles later dout = 1023, dout_valid pulse, dout_ch = 0.
- target[1] = 255, SLEW_STEP = 0, din = -2048 on ch 1 -> dout = -2040. Then din = -1, gain 1 -> dout = -1 (floor behaviour).
- SLEW_STEP = 4: target[2] = 100 from 0, then 30 samples of din = 256 on ch 2 -> gains used are 0, 4, 8, ..., 96, then 100 from sample 26 on. Outputs are 0, 4, ..., 100. Next, target = 102 -> next gain used is 100, after that 102 (no overshoot).
- Interleave: ch 0 to ch 3 back-to-back with distinct gains, plus ch 5 with CHANNELS = 4 -> four in-order outputs on consecutive cycles with correct tags, no output for ch 5.
- Same-cycle amp_wr and din_valid on ch 0 (cur = 50, new target = 0, SLEW_STEP = 4) -> that sample uses gain 50 and cur stays 50; the following sample uses 50, then ramps 46, 42, ...
- Assert reset_n low while two samples are in flight -> dout_valid stays 0 and dout = 0 immediately; after release, cur and target read 0, so the first output is 0.
